// File: rtl/gsim_pkg.sv
// Shared GSIM definitions: shift-register command codes, vector length and
// the state encoding of the shift-register sequencer.
package gsim_pkg;

    localparam logic [1:0] SH0 = 2'b00;
    localparam logic [1:0] SH1 = 2'b01;
    localparam logic [1:0] SH4 = 2'b10;
    localparam logic [1:0] SH5 = 2'b11;

    localparam int N_X   = 16;
    localparam int IDX_W = $clog2(N_X);

    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_LOAD  = 3'd1,
        SEQ_ITER  = 3'd2,
        SEQ_DRAIN = 3'd3,
        SEQ_FLUSH = 3'd4
    } seq_state_e;

    // True on the last slot of a 16-entry pass.
    function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_X - 1));
    endfunction

endpackage

// File: rtl/gsim_shreg_seq.sv
// Sequencer for the GSIM x-vector shift register: clears it, inserts each
// updated x from the PE, then drains the converged vector in index order.
module gsim_shreg_seq
    import gsim_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int N_ITER    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    input  logic [BIT_WIDTH-1:0] pe_x,
    input  logic                 pe_valid,
    output logic                 pe_ready,
    output logic [1:0]           sh_ctrl,
    output logic                 sh_en,
    output logic [BIT_WIDTH-1:0] sh_in,
    input  logic [BIT_WIDTH-1:0] sh_out0,
    output logic                 out_valid,
    output logic [3:0]           out_idx,
    output logic [BIT_WIDTH-1:0] out_x,
    output logic                 done
);

    localparam int               ITW       = $clog2(N_ITER + 1);
    localparam logic [ITW-1:0]   ITER_LAST = ITW'(N_ITER - 1);

    seq_state_e           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [ITW-1:0]       iter_q, iter_d;
    logic                 out_valid_q, out_valid_d;
    logic [3:0]           out_idx_q, out_idx_d;
    logic [BIT_WIDTH-1:0] out_x_q, out_x_d;
    logic                 done_q, done_d;

    // Next-state, counter and shift-register command decode.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        iter_d      = iter_q;
        out_valid_d = 1'b0;
        out_idx_d   = out_idx_q;
        out_x_d     = out_x_q;
        done_d      = 1'b0;
        sh_ctrl     = SH0;
        sh_en       = 1'b0;
        sh_in       = '0;
        pe_ready    = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    state_d = SEQ_LOAD;
                    idx_d   = '0;
                    iter_d  = '0;
                end else begin
                    state_d = SEQ_IDLE;
                end
            end

            SEQ_LOAD: begin
                sh_ctrl = SH1;
                sh_en   = 1'b1;
                idx_d   = idx_q + IDX_W'(1);
                if (is_last_idx(idx_q)) begin
                    state_d = SEQ_ITER;
                    idx_d   = '0;
                end else begin
                    state_d = SEQ_LOAD;
                end
            end

            SEQ_ITER: begin
                pe_ready = 1'b1;
                sh_in    = pe_x;
                if (pe_valid) begin
                    sh_ctrl = SH1;
                    sh_en   = 1'b1;
                    idx_d   = idx_q + IDX_W'(1);
                    // A full sweep ends on slot 15; the last sweep hands over to the drain.
                    if (is_last_idx(idx_q)) begin
                        if (iter_q == ITER_LAST) begin
                            state_d = SEQ_DRAIN;
                            idx_d   = '0;
                        end else begin
                            iter_d = iter_q + ITW'(1);
                        end
                    end else begin
                        iter_d = iter_q;
                    end
                end else begin
                    sh_ctrl = SH0;
                    sh_en   = 1'b0;
                end
            end

            SEQ_DRAIN: begin
                // Plain rotate: slot 0 presents x[idx] while idx steps through the vector.
                sh_ctrl     = SH1;
                sh_en       = 1'b0;
                out_valid_d = 1'b1;
                out_idx_d   = 4'(idx_q);
                out_x_d     = sh_out0;
                idx_d       = idx_q + IDX_W'(1);
                if (is_last_idx(idx_q)) begin
                    state_d = SEQ_FLUSH;
                end else begin
                    state_d = SEQ_DRAIN;
                end
            end

            SEQ_FLUSH: begin
                done_d  = 1'b1;
                state_d = SEQ_IDLE;
            end

            default: begin
                state_d = SEQ_IDLE;
                idx_d   = '0;
                iter_d  = '0;
            end
        endcase
    end

    // State, counters and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEQ_IDLE;
            idx_q       <= '0;
            iter_q      <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= 4'd0;
            out_x_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            iter_q      <= iter_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_x_q     <= out_x_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != SEQ_IDLE);
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_x     = out_x_q;
    assign done      = done_q;

endmodule

// File: tb/tb_gsim_shreg_seq.sv
// Directed bench for gsim_shreg_seq with a behavioural 16-slot shift register
// attached to its sh_* outputs.
module tb_gsim_shreg_seq;
    import gsim_pkg::*;

    localparam int BW  = 32;
    localparam int NIT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          pe_valid;
    logic [BW-1:0] pe_x;
    logic          busy, pe_ready, sh_en, out_valid, done;
    logic [1:0]    sh_ctrl;
    logic [BW-1:0] sh_in, sh_out0, out_x;
    logic [3:0]    out_idx;

    int total = 0;
    int bad   = 0;
    int xfer_cnt  = 0;
    int shift_cnt = 0;
    int s0, x0;

    logic [BW-1:0] sr [16];

    gsim_shreg_seq #(.BIT_WIDTH(BW), .N_ITER(NIT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .pe_x(pe_x), .pe_valid(pe_valid), .pe_ready(pe_ready),
        .sh_ctrl(sh_ctrl), .sh_en(sh_en), .sh_in(sh_in), .sh_out0(sh_out0),
        .out_valid(out_valid), .out_idx(out_idx), .out_x(out_x), .done(done)
    );

    always #5 clk = ~clk;

    // Shift register: shift toward slot 0, slot 15 takes sh_in or wraps slot 0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) sr[i] <= '0;
        end else if (sh_ctrl == SH1) begin
            for (int i = 0; i < 15; i++) sr[i] <= sr[i+1];
            sr[15] <= sh_en ? sh_in : sr[0];
        end
    end
    assign sh_out0 = sr[0];

    always @(posedge clk) begin
        if (rst_n && pe_valid && pe_ready) xfer_cnt <= xfer_cnt + 1;
        if (rst_n && sh_ctrl != SH0) shift_cnt <= shift_cnt + 1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_busy"},      64'(busy),      64'd0);
        chk({pfx, "_pe_ready"},  64'(pe_ready),  64'd0);
        chk({pfx, "_sh_ctrl"},   64'(sh_ctrl),   64'd0);
        chk({pfx, "_sh_en"},     64'(sh_en),     64'd0);
        chk({pfx, "_sh_in"},     64'(sh_in),     64'd0);
        chk({pfx, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({pfx, "_out_idx"},   64'(out_idx),   64'd0);
        chk({pfx, "_out_x"},     64'(out_x),     64'd0);
        chk({pfx, "_done"},      64'(done),      64'd0);
    endtask

    // Entered one step after the start edge; returns in the first ITER cycle.
    task automatic load16();
        for (int k = 0; k < 16; k++) begin
            chk("load_ctrl",  64'(sh_ctrl),  64'(SH1));
            chk("load_en",    64'(sh_en),    64'd1);
            chk("load_in",    64'(sh_in),    64'd0);
            chk("load_ready", 64'(pe_ready), 64'd0);
            chk("load_busy",  64'(busy),     64'd1);
            cyc();
        end
        chk("iter_ready", 64'(pe_ready), 64'd1);
    endtask

    task automatic feed(input logic [BW-1:0] v, input int gaps);
        for (int g = 0; g < gaps; g++) begin
            pe_valid = 1'b0;
            pe_x     = v ^ 32'h0000_FFFF;
            #1;
            chk("gap_ctrl",  64'(sh_ctrl),  64'(SH0));
            chk("gap_en",    64'(sh_en),    64'd0);
            chk("gap_ready", 64'(pe_ready), 64'd1);
            cyc();
        end
        pe_valid = 1'b1;
        pe_x     = v;
        #1;
        chk("xfer_ctrl", 64'(sh_ctrl), 64'(SH1));
        chk("xfer_en",   64'(sh_en),   64'd1);
        chk("xfer_in",   64'(sh_in),   64'(v));
        cyc();
        pe_valid = 1'b0;
    endtask

    // Entered in the first DRAIN cycle; noise drives pe_valid/start throughout.
    task automatic drain(input int base, input logic noise);
        pe_valid = noise;
        start    = noise;
        pe_x     = 32'd999;
        #1;
        chk("drain_ctrl",   64'(sh_ctrl),   64'(SH1));
        chk("drain_en",     64'(sh_en),     64'd0);
        chk("drain_pre_ov", 64'(out_valid), 64'd0);
        cyc();
        for (int k = 0; k < 16; k++) begin
            chk("out_valid", 64'(out_valid), 64'd1);
            chk("out_idx",   64'(out_idx),   64'(k));
            chk("out_x",     64'(out_x),     64'(base + k));
            chk("out_done",  64'(done),      64'd0);
            chk("out_busy",  64'(busy),      64'd1);
            chk("out_sh_en", 64'(sh_en),     64'd0);
            cyc();
        end
        pe_valid = 1'b0;
        start    = 1'b0;
        chk("done_pulse", 64'(done),      64'd1);
        chk("done_busy",  64'(busy),      64'd0);
        chk("done_ov",    64'(out_valid), 64'd0);
        cyc();
        chk("done_clear", 64'(done), 64'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        pe_valid = 1'b0;
        pe_x     = '0;
        repeat (2) cyc();
        chk_reset("rst");
        rst_n = 1'b1;
        cyc();

        // pe_valid alone in IDLE must not shift or count
        pe_valid = 1'b1;
        pe_x     = 32'd999;
        #1;
        chk("idle_ctrl",  64'(sh_ctrl),  64'(SH0));
        chk("idle_ready", 64'(pe_ready), 64'd0);
        s0 = shift_cnt;
        x0 = xfer_cnt;
        cyc();
        chk("idle_busy",   64'(busy),      64'd0);
        chk("idle_shifts", 64'(shift_cnt), 64'(s0));
        chk("idle_xfers",  64'(xfer_cnt),  64'(x0));

        // Job 1: start together with pe_valid, noise during LOAD and DRAIN
        start = 1'b1;
        #1;
        chk("start_pv_ctrl", 64'(sh_ctrl), 64'(SH0));
        chk("start_pv_en",   64'(sh_en),   64'd0);
        cyc();
        load16();
        start = 1'b0;
        for (int i = 0; i < 16; i++) feed(BW'(50 + i), 0);
        for (int i = 0; i < 16; i++) feed(BW'(100 + i), 0);
        drain(100, 1'b1);
        chk("job1_xfers",  64'(xfer_cnt - x0),  64'd32);
        chk("job1_shifts", 64'(shift_cnt - s0), 64'd64);

        // Job 2: stalled transfers, start pulse while busy in ITER
        s0 = shift_cnt;
        x0 = xfer_cnt;
        start = 1'b1;
        cyc();
        start = 1'b0;
        load16();
        for (int i = 0; i < 16; i++) feed(BW'(300 + i), (i % 4 == 1) ? 1 : ((i % 4 == 3) ? 2 : 0));
        start = 1'b1;
        #1;
        chk("busy_start_ctrl", 64'(sh_ctrl), 64'(SH0));
        cyc();
        start = 1'b0;
        chk("busy_start_ready", 64'(pe_ready), 64'd1);
        chk("busy_start_busy",  64'(busy),     64'd1);
        for (int i = 0; i < 16; i++) feed(BW'(200 + i), (i == 8) ? 6 : ((i % 3 == 2) ? 1 : 0));
        drain(200, 1'b1);
        chk("job2_xfers",  64'(xfer_cnt - x0),  64'd32);
        chk("job2_shifts", 64'(shift_cnt - s0), 64'd64);

        // Job 3: asynchronous reset in the middle of ITER
        start = 1'b1;
        cyc();
        start = 1'b0;
        load16();
        for (int i = 0; i < 5; i++) feed(BW'(400 + i), 0);
        pe_valid = 1'b1;
        pe_x     = 32'd77;
        rst_n    = 1'b0;
        #1;
        chk_reset("midrst");
        pe_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_rst_busy", 64'(busy), 64'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        load16();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
